// File: rtl/alu_pkg.sv
// Shared ALU result definitions: flag bit positions and the buffered result entry layout.
package alu_pkg;
    localparam int ALU_W  = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [ALU_W-1:0] y;
        logic [3:0]       flags;
    } result_entry_t;
endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {N,Z,C,V} flag builder for an ALU result word.
// Zero latency; no handshake.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_c,
    input  logic             in_v,
    output logic [3:0]       flags
);
    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = in_y[WIDTH-1];
        flags[FLAG_Z] = (in_y == '0);
        flags[FLAG_C] = in_c;
        flags[FLAG_V] = in_v;
    end
endmodule

// File: rtl/alu_result_stage.sv
// ALU result FIFO with derived flags, sticky overflow and saturating overflow counter.
// One-cycle push-to-valid latency, no bypass; in_ready = !full && !flush, independent of out_ready.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_y,
    input  logic                     in_c,
    input  logic                     in_v,
    input  logic                     flush,
    input  logic                     clr_sticky,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sticky_v,
    output logic [CNT_W-1:0]         ovf_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_mem_y [DEPTH];
    logic [3:0]       r_mem_f [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out_y;
    logic [3:0]       r_out_f;
    logic             r_sticky;
    logic [CNT_W-1:0] r_ovf;

    logic [3:0]       w_flags;
    logic             w_full, w_push, w_pop, w_vpush;
    logic [AW-1:0]    w_wr_nxt, w_rd_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_head_y;
    logic [3:0]       w_head_f;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .in_y  (in_y),
        .in_c  (in_c),
        .in_v  (in_v),
        .flags (w_flags)
    );

    assign w_full    = (r_cnt == FULL_CNT);
    assign in_ready  = !w_full && !flush;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = (r_cnt != '0) && out_ready;
    assign w_vpush   = w_push && in_v;
    assign out_valid = (r_cnt != '0);
    assign out_y     = r_out_y;
    assign out_flags = r_out_f;
    assign count     = r_cnt;
    assign sticky_v  = r_sticky;
    assign ovf_cnt   = r_ovf;

    always_comb begin
        w_wr_nxt  = r_wr_ptr;
        w_rd_nxt  = r_rd_ptr;
        w_cnt_nxt = r_cnt;
        if (flush) begin
            w_wr_nxt  = '0;
            w_rd_nxt  = '0;
            w_cnt_nxt = '0;
        end else begin
            if (w_push) w_wr_nxt = r_wr_ptr + 1'b1;
            if (w_pop)  w_rd_nxt = r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 1'b1;
            else if (!w_push && w_pop) w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // The output register preloads the next head; a push landing in that slot is forwarded.
    always_comb begin
        w_head_y = r_mem_y[w_rd_nxt];
        w_head_f = r_mem_f[w_rd_nxt];
        if (w_push && (r_wr_ptr == w_rd_nxt)) begin
            w_head_y = in_y;
            w_head_f = w_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_y[r_wr_ptr] <= in_y;
            r_mem_f[r_wr_ptr] <= w_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_out_y  <= '0;
            r_out_f  <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_cnt    <= w_cnt_nxt;
            if (w_cnt_nxt != '0) begin
                r_out_y <= w_head_y;
                r_out_f <= w_head_f;
            end
        end
    end

    // A V push in the same cycle as a clear wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_ovf    <= '0;
        end else begin
            if (w_vpush)         r_sticky <= 1'b1;
            else if (clr_sticky) r_sticky <= 1'b0;

            if (clr_sticky)                    r_ovf <= w_vpush ? CNT_ONE : '0;
            else if (w_vpush && r_ovf != CNT_MAX) r_ovf <= r_ovf + 1'b1;
        end
    end
endmodule
